aclk_set_ctrl: RTL and testbench

- Button-driven set controller directly upstream of the alarm-clock core.
- Turns debounced single-cycle button pulses into validated BCD digits (H_in1, H_in0, M_in1, M_in0) and a one-cycle LD_time or LD_alarm pulse.
- Time edits are seeded from the core's live outputs. Alarm edits are seeded from an internal shadow of the last loaded alarm.
- Runs on the core's 10 Hz clock.

---
 rtl/aclk_set_pkg.sv | 81 ++++++++
 rtl/aclk_idle_timer.sv | 32 +++
 rtl/aclk_set_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aclk_set_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_set_pkg.sv
// Shared types and digit rules for the alarm-clock set controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aclk_set_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H1 = 3'd1,
    EDIT_H0 = 3'd2,
    EDIT_M1 = 3'd3,
    EDIT_M0 = 3'd4,
    LOAD    = 3'd5
  } state_t;

  typedef enum logic {
    TIME  = 1'b0,
    ALARM = 1'b1
  } target_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } digits_t;

  localparam logic [3:0] H1_MAX     = 4'd2;
  localparam logic [3:0] H0_MAX     = 4'd9;
  localparam logic [3:0] H0_MAX_20H = 4'd3;
  localparam logic [3:0] M1_MAX     = 4'd5;
  localparam logic [3:0] M0_MAX     = 4'd9;

  localparam logic [1:0] CUR_H1 = 2'd0;
  localparam logic [1:0] CUR_H0 = 2'd1;
  localparam logic [1:0] CUR_M1 = 2'd2;
  localparam logic [1:0] CUR_M0 = 2'd3;

  // Wrapped increment of the digit at 'cursor'; the hour LSB range depends on h1.
  function automatic logic [3:0] next_digit(input logic [1:0] cursor,
                                            input logic [1:0] h1,
                                            input logic [3:0] value);
    logic [3:0] lim;
    case (cursor)
      CUR_H1:  lim = H1_MAX;
      CUR_H0:  lim = (h1 == H1_MAX[1:0]) ? H0_MAX_20H : H0_MAX;
      CUR_M1:  lim = M1_MAX;
      default: lim = M0_MAX;
    endcase
    return (value >= lim) ? 4'd0 : value + 4'd1;
  endfunction

  // Pull every digit of a seed into its legal range (20-23h limits the hour LSB).
  function automatic digits_t clamp_digits(input digits_t d);
    digits_t r;
    r = d;
    if ({2'b00, r.h1} > H1_MAX) r.h1 = H1_MAX[1:0];
    if (r.h1 == H1_MAX[1:0]) begin
      if (r.h0 > H0_MAX_20H) r.h0 = H0_MAX_20H;
    end else if (r.h0 > H0_MAX) begin
      r.h0 = H0_MAX;
    end
    if (r.m1 > M1_MAX) r.m1 = M1_MAX;
    if (r.m0 > M0_MAX) r.m0 = M0_MAX;
    return r;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_H1) || (s == EDIT_H0) || (s == EDIT_M1) || (s == EDIT_M0);
  endfunction

  // Digit under the cursor for an edit state; 0 outside editing.
  function automatic logic [1:0] cursor_of(input state_t s);
    case (s)
      EDIT_H0: return CUR_H0;
      EDIT_M1: return CUR_M1;
      EDIT_M0: return CUR_M0;
      default: return CUR_H1;
    endcase
  endfunction

endpackage

// File: rtl/aclk_idle_timer.sv
// Idle counter for edit mode: flags expiry after TIMEOUT_CYC-1 un-pressed cycles.
// Latency: expired_o is a decode of the registered count (visible same cycle).
// Backpressure: none; clear_i overrides tick_i, count saturates at expiry.
module aclk_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 600,
  parameter int unsigned TMR_W       = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] cnt_q;

  // Count idle cycles, holding at the terminal value until the owner clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (tick_i && !expired_o) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/aclk_set_ctrl.sv
// Button-driven BCD time/alarm editor feeding the alarm-clock core load ports.
// Latency: LD strobe registered, high the cycle after the committing press.
// Backpressure: none; one action per cycle, cancel > ok > next > inc.
module aclk_set_ctrl
  import aclk_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 600,
  parameter int unsigned TMR_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] cursor
);

  state_t     state_q, state_d;
  target_t    target_q, target_d;
  digits_t    dig_q, dig_d;
  digits_t    bak_q, bak_d;
  digits_t    shadow_q, shadow_d;
  logic       ld_time_q, ld_time_d;
  logic       ld_alarm_q, ld_alarm_d;
  logic       editing_q, editing_d;
  logic [1:0] cursor_q, cursor_d;

  digits_t    core_dig;
  logic       any_btn;
  logic       expired;
  logic       timer_clr;
  logic [3:0] cur_val;
  logic [3:0] inc_val;

  assign core_dig  = '{h1: H_out1, h0: H_out0, m1: M_out1, m0: M_out0};
  assign any_btn   = btn_set_time | btn_set_alarm | btn_inc | btn_next | btn_ok | btn_cancel;
  // Any press while editing restarts the idle window; outside editing it is held at 0.
  assign timer_clr = !is_edit(state_q) || any_btn;

  aclk_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clr),
    .tick_i   (1'b1),
    .expired_o(expired)
  );

  // Select the digit under the cursor, zero-extended, for the shared incrementer.
  always_comb begin
    cur_val = 4'd0;
    case (state_q)
      EDIT_H1: cur_val = {2'b00, dig_q.h1};
      EDIT_H0: cur_val = dig_q.h0;
      EDIT_M1: cur_val = dig_q.m1;
      EDIT_M0: cur_val = dig_q.m0;
      default: cur_val = 4'd0;
    endcase
  end

  assign inc_val = next_digit(cursor_of(state_q), dig_q.h1, cur_val);

  // Next-state, digit edits and registered-output precompute.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dig_d    = dig_q;
    bak_d    = bak_q;
    shadow_d = shadow_q;

    case (state_q)
      IDLE: begin
        if (btn_set_time) begin
          bak_d    = dig_q;
          dig_d    = clamp_digits(core_dig);
          target_d = TIME;
          state_d  = EDIT_H1;
        end else if (btn_set_alarm) begin
          bak_d    = dig_q;
          dig_d    = clamp_digits(shadow_q);
          target_d = ALARM;
          state_d  = EDIT_H1;
        end
      end

      EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0: begin
        // A timeout only aborts on a quiet cycle; any press takes precedence.
        if (btn_cancel || (expired && !any_btn)) begin
          state_d = IDLE;
          dig_d   = bak_q;
        end else if (btn_ok) begin
          state_d = LOAD;
        end else if (btn_next) begin
          case (state_q)
            EDIT_H1: state_d = EDIT_H0;
            EDIT_H0: state_d = EDIT_M1;
            EDIT_M1: state_d = EDIT_M0;
            default: state_d = LOAD;
          endcase
        end else if (btn_inc) begin
          case (state_q)
            EDIT_H1: begin
              dig_d.h1 = inc_val[1:0];
              // Rolling into the 20s must not leave an illegal hour like 24-29.
              if ((inc_val[1:0] == H1_MAX[1:0]) && (dig_q.h0 > H0_MAX_20H)) begin
                dig_d.h0 = H0_MAX_20H;
              end
            end
            EDIT_H0: dig_d.h0 = inc_val;
            EDIT_M1: dig_d.m1 = inc_val;
            default: dig_d.m0 = inc_val;
          endcase
        end
      end

      LOAD: begin
        state_d = IDLE;
        if (target_q == ALARM) shadow_d = dig_q;
      end

      default: state_d = IDLE;
    endcase

    ld_time_d  = (state_d == LOAD) && (target_d == TIME);
    ld_alarm_d = (state_d == LOAD) && (target_d == ALARM);
    editing_d  = is_edit(state_d);
    cursor_d   = is_edit(state_d) ? cursor_of(state_d) : 2'd0;
  end

  // State and output registers; reset aborts any edit without a load strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      target_q   <= TIME;
      dig_q      <= '0;
      bak_q      <= '0;
      shadow_q   <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      editing_q  <= 1'b0;
      cursor_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      dig_q      <= dig_d;
      bak_q      <= bak_d;
      shadow_q   <= shadow_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      editing_q  <= editing_d;
      cursor_q   <= cursor_d;
    end
  end

  assign H_in1    = dig_q.h1;
  assign H_in0    = dig_q.h0;
  assign M_in1    = dig_q.m1;
  assign M_in0    = dig_q.m0;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign editing  = editing_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_aclk_set_ctrl.sv
// Self-checking bench for aclk_set_ctrl against a digit-array reference model.
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_aclk_set_ctrl;

  localparam int T = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_set_time = 1'b0, btn_set_alarm = 1'b0, btn_inc = 1'b0;
  logic       btn_next = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
  logic [1:0] H_out1 = 2'd0;
  logic [3:0] H_out0 = 4'd0, M_out1 = 4'd0, M_out0 = 4'd0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing;
  logic [1:0] cursor;

  always #5 clk = ~clk;

  aclk_set_ctrl #(.TIMEOUT_CYC(T), .TMR_W(10)) dut (
    .clk(clk), .reset(reset),
    .btn_set_time(btn_set_time), .btn_set_alarm(btn_set_alarm), .btn_inc(btn_inc),
    .btn_next(btn_next), .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .cursor(cursor)
  );

  int vectors = 0;
  int fails   = 0;

  // Reference model: mode 0 idle, 1 editing, 2 loading; digits as plain integers.
  int m_dig[4], m_bak[4], m_sh[4];
  int m_mode = 0, m_cur = 0, m_idle = 0;
  bit m_alarm = 1'b0, m_ldt = 1'b0, m_lda = 1'b0;

  function automatic int lim_of(int pos, int h1);
    if (pos == 0) return 2;
    if (pos == 1) return (h1 == 2) ? 3 : 9;
    if (pos == 2) return 5;
    return 9;
  endfunction

  task automatic model_step(input bit rst_n, input bit st, input bit sa, input bit inc,
                            input bit nx, input bit ok, input bit cn);
    bit any;
    any = st | sa | inc | nx | ok | cn;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = 0; m_bak[i] = 0; m_sh[i] = 0;
      end
      m_mode = 0; m_cur = 0; m_idle = 0; m_alarm = 1'b0;
    end else if (m_mode == 0) begin
      if (st || sa) begin
        m_bak = m_dig;
        if (st) begin
          m_dig[0] = H_out1; m_dig[1] = H_out0; m_dig[2] = M_out1; m_dig[3] = M_out0;
          m_alarm = 1'b0;
        end else begin
          m_dig = m_sh;
          m_alarm = 1'b1;
        end
        if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
        m_mode = 1; m_cur = 0; m_idle = 0;
      end
    end else if (m_mode == 1) begin
      if (cn || (!any && m_idle == T - 1)) begin
        m_dig = m_bak;
        m_mode = 0;
      end else if (ok) begin
        m_mode = 2;
      end else if (nx) begin
        if (m_cur == 3) m_mode = 2;
        else m_cur++;
      end else if (inc) begin
        m_dig[m_cur] = (m_dig[m_cur] + 1) % (lim_of(m_cur, m_dig[0]) + 1);
        if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
      end
      m_idle = any ? 0 : m_idle + 1;
    end else begin
      m_mode = 0;
      if (m_alarm) m_sh = m_dig;
    end
    m_ldt = rst_n && (m_mode == 2) && !m_alarm;
    m_lda = rst_n && (m_mode == 2) && m_alarm;
  endtask

  function automatic logic [18:0] exp_vec();
    return {2'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]),
            m_ldt, m_lda, (m_mode == 1), (m_mode == 1) ? 2'(m_cur) : 2'd0};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, editing, cursor};
  endfunction

  task automatic set_core(input int h1, input int h0, input int m1, input int m0);
    H_out1 = 2'(h1); H_out0 = 4'(h0); M_out1 = 4'(m1); M_out0 = 4'(m0);
  endtask

  // One clock: drive pulses, let the edge sample them, advance the model, settle.
  task automatic step(input bit st, input bit sa, input bit inc, input bit nx,
                      input bit ok, input bit cn);
    btn_set_time = st; btn_set_alarm = sa; btn_inc = inc;
    btn_next = nx; btn_ok = ok; btn_cancel = cn;
    @(posedge clk);
    model_step(reset, st, sa, inc, nx, ok, cn);
    #1;
    btn_set_time = 0; btn_set_alarm = 0; btn_inc = 0;
    btn_next = 0; btn_ok = 0; btn_cancel = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_core(1, 2, 3, 4);
    repeat (2) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if (obs_vec() !== 19'd0) begin
        fails++; $display("FAIL reset_init got %h want %h", obs_vec(), 19'd0);
      end
    end
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_enter got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 0, 1, 0, 0, 0);
    reset = 1'b0;
    repeat (2) begin
      step(0, 0, 0, 0, 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_mid got %h want %h", obs_vec(), exp_vec());
      end
    end
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs_vec() !== 19'd0) begin
      fails++; $display("FAIL reset_release got %h want %h", obs_vec(), 19'd0);
    end
  endtask

  task automatic test_set_time();
    set_core(1, 4, 3, 7);
    step(1, 0, 0, 0, 0, 0);
    vectors++;
    if ({editing, cursor, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 2'd0, 2'd1, 4'd4, 4'd3, 4'd7}) begin
      fails++; $display("FAIL time_seed got %b%h %h%h:%h%h want 1 0 14:37",
                        editing, cursor, H_in1, H_in0, M_in1, M_in0);
    end
    step(0, 0, 1, 0, 0, 0);
    vectors++;
    if ({H_in1, H_in0} !== {2'd2, 4'd3}) begin
      fails++; $display("FAIL time_clamp got %h%h want 23", H_in1, H_in0);
    end
    repeat (3) begin
      step(0, 0, 0, 1, 0, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL time_next got %h want %h", obs_vec(), exp_vec());
      end
    end
    step(0, 0, 1, 0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL time_inc_m0 got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 1, 0, 0);
    vectors++;
    if ({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm} !== {2'd2, 4'd3, 4'd3, 4'd8, 1'b1, 1'b0}) begin
      fails++; $display("FAIL time_load got %h%h:%h%h ld %b%b want 23:38 ld 10",
                        H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if ({H_in1, H_in0, M_in1, M_in0, LD_time, editing} !== {2'd2, 4'd3, 4'd3, 4'd8, 1'b0, 1'b0}) begin
      fails++; $display("FAIL time_hold got %h%h:%h%h ld %b ed %b want 23:38 ld 0 ed 0",
                        H_in1, H_in0, M_in1, M_in0, LD_time, editing);
    end
  endtask

  task automatic test_alarm();
    step(0, 1, 0, 0, 0, 0);
    vectors++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 14'd0}) begin
      fails++; $display("FAIL alarm_seed0 got %h want %h", obs_vec(), exp_vec());
    end
    repeat (3) begin
      step(0, 0, 1, 0, 0, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL alarm_inc_h1 got %h want %h", obs_vec(), exp_vec());
      end
    end
    step(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({LD_alarm, LD_time, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 1'b0, 14'd0}) begin
      fails++; $display("FAIL alarm_load0 got %h want ld_alarm with 00:00", obs_vec());
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({LD_alarm, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 2'd1, 12'd0}) begin
      fails++; $display("FAIL alarm_load10 got %h want ld_alarm with 10:00", obs_vec());
    end
    step(0, 0, 0, 0, 0, 0);
    set_core(0, 5, 5, 5);
    step(0, 1, 0, 0, 0, 0);
    vectors++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 2'd1, 12'd0}) begin
      fails++; $display("FAIL alarm_shadow got %h%h:%h%h want 10:00", H_in1, H_in0, M_in1, M_in0);
    end
    step(0, 0, 0, 0, 0, 1);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL alarm_cancel got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap_cancel();
    int pre[4];
    pre = m_dig;
    set_core(0, 9, 5, 2);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    vectors++;
    if ({cursor, M_in1} !== {2'd2, 4'd5}) begin
      fails++; $display("FAIL wrap_pos got cur %0d m1 %0d want cur 2 m1 5", cursor, M_in1);
    end
    step(0, 0, 1, 0, 0, 0);
    vectors++;
    if (M_in1 !== 4'd0) begin
      fails++; $display("FAIL wrap_m1 got %0d want 0", M_in1);
    end
    step(0, 0, 1, 0, 0, 1);
    vectors++;
    if ({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, editing} !==
        {2'(pre[0]), 4'(pre[1]), 4'(pre[2]), 4'(pre[3]), 3'b000}) begin
      fails++; $display("FAIL cancel_revert got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    int pre[4];
    set_core(2, 1, 4, 6);
    pre = m_dig;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i < T; i++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL timeout_wait cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if ({editing, LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0} !==
        {3'b000, 2'(pre[0]), 4'(pre[1]), 4'(pre[2]), 4'(pre[3])}) begin
      fails++; $display("FAIL timeout_abort got %h want %h", obs_vec(), exp_vec());
    end
    step(1, 0, 0, 0, 0, 0);
    repeat (T - 1) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    vectors++;
    if ({editing, H_in1} !== {1'b1, 2'd0}) begin
      fails++; $display("FAIL timeout_press got ed %b h1 %0d want ed 1 h1 0", editing, H_in1);
    end
    repeat (T - 1) step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (editing !== 1'b1) begin
      fails++; $display("FAIL timeout_restart got %b want 1", editing);
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec() || editing !== 1'b0) begin
      fails++; $display("FAIL timeout_abort2 got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_both_load();
    set_core(2, 9, 5, 9);
    step(1, 1, 0, 0, 0, 0);
    vectors++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 2'd2, 4'd3, 4'd5, 4'd9}) begin
      fails++; $display("FAIL both_seed got %h%h:%h%h want 23:59", H_in1, H_in0, M_in1, M_in0);
    end
    step(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({LD_time, LD_alarm} !== 2'b10) begin
      fails++; $display("FAIL both_target got ld %b%b want 10", LD_time, LD_alarm);
    end
    step(1, 1, 1, 1, 1, 1);
    vectors++;
    if ({editing, LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0} !== {3'b000, 2'd2, 4'd3, 4'd5, 4'd9}) begin
      fails++; $display("FAIL load_ignore got %h want idle 23:59", obs_vec());
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL load_after got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_core($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
      end
      reset = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_alarm();
    test_wrap_cancel();
    test_timeout();
    test_both_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
